// File: rtl/lc2k_pkg.sv
// Shared definitions for the LC2K data-memory subsystem.
//
// Contents:
//   LC2K_DATA_W / LC2K_ADDR_W : default word width and data-memory word address width
//   PORT_CPU / PORT_DBG       : requester indices (CPU load/store port, loader/debug port)
//   arb_state_t               : mem_arbiter response FSM state type
//   port_onehot()             : turns a port index bit into a one-hot 2-bit vector
package lc2k_pkg;

  localparam int LC2K_DATA_W = 32;
  localparam int LC2K_ADDR_W = 6;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // IDLE: no response owed next cycle; PEND: a response is owed to the tagged port
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } arb_state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    port_onehot = port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a bounded port-1 lock.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : [1:0] request valid per port
//   lock1       : port 1 asks to keep the grant while it holds it
//   grant       : [1:0] one-hot grant (combinational); a grant is always an accept
//
// State: last granted port (resets to port 1 so port 0 wins the first contention)
// and a saturating count of consecutive port-1 grants made while port 0 waited.
module rr_arbiter2
  import lc2k_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic       lock1,
  output logic [1:0] grant
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_expired;

  assign lock_expired = (lock_cnt >= CNT_W'(MAX_LOCK));

  // Grant is forced off while reset is asserted so nothing is accepted during reset.
  // Under contention an expired lock hands the slot to port 0 first, then lock1
  // keeps port 1 on, otherwise the port not granted last wins.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      case (req_valid)
        2'b01: grant = 2'b01;
        2'b10: grant = 2'b10;
        2'b11: begin
          if (lock_expired)
            grant = 2'b01;
          else if (last_grant)
            grant = lock1 ? 2'b10 : 2'b01;
          else
            grant = 2'b10;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // The counter only grows while port 0 is actually waiting and saturates at MAX_LOCK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lock_cnt   <= '0;
    end else begin
      if (grant[PORT_CPU])
        last_grant <= 1'b0;
      else if (grant[PORT_DBG])
        last_grant <= 1'b1;

      if (grant[PORT_CPU] || !req_valid[PORT_CPU])
        lock_cnt <= '0;
      else if (grant[PORT_DBG] && !lock_expired)
        lock_cnt <= lock_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the LC2K single-port data memory.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_write     : [1:0] per-port request valid and store flag
//   req_addr0/1, req_wdata0/1 : per-port word address and store data
//   lock1                   : port 1 burst lock request
//   req_ready               : [1:0] per-port accept (combinational)
//   rsp_valid               : [1:0] per-port response strobe, one cycle after accept
//   rsp_rdata               : load data (mem_rdata) or 0 for a store ack
//   mem_en/mem_we/mem_addr/mem_wdata : memory command, driven in the accept cycle
//   mem_rdata               : memory read data, valid the cycle after a read command
//
// One access per cycle; a new accept may overlap the response of the previous one.
module mem_arbiter
  import lc2k_pkg::*;
#(
  parameter int DATA_W   = LC2K_DATA_W,
  parameter int ADDR_W   = LC2K_ADDR_W,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic              lock1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] grant;
  logic       accept;
  logic       win_port;

  arb_state_t state, next_state;
  logic       tag_port, next_tag_port;
  logic       tag_write, next_tag_write;

  rr_arbiter2 #(
    .MAX_LOCK (MAX_LOCK)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .lock1     (lock1),
    .grant     (grant)
  );

  assign accept    = |grant;
  assign win_port  = grant[PORT_DBG];
  assign req_ready = grant;

  // Memory command is the winner's request; everything reads zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept) begin
      mem_en    = 1'b1;
      mem_we    = req_write[win_port];
      mem_addr  = win_port ? req_addr1  : req_addr0;
      mem_wdata = win_port ? req_wdata1 : req_wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tag_port  <= 1'b0;
      tag_write <= 1'b0;
    end else begin
      state     <= next_state;
      tag_port  <= next_tag_port;
      tag_write <= next_tag_write;
    end
  end

  // Every accept owes exactly one response next cycle, whatever the current state,
  // so both states share the same transition rule.  The response outputs come only
  // from registered state, which keeps them independent of a same-cycle accept.
  always_comb begin
    next_state     = ST_IDLE;
    next_tag_port  = tag_port;
    next_tag_write = tag_write;
    rsp_valid      = 2'b00;
    rsp_rdata      = '0;

    case (state)
      ST_IDLE, ST_PEND: begin
        if (accept) begin
          next_state     = ST_PEND;
          next_tag_port  = win_port;
          next_tag_write = mem_we;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    if (state == ST_PEND) begin
      rsp_valid = port_onehot(tag_port);
      if (!tag_write)
        rsp_rdata = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (built with MAX_LOCK=4).
// A behavioural model (winner choice from the arbitration rules, a reference
// memory array and a one-deep expected-response record) predicts every output
// each cycle; directed sequences add fixed expected values on top.
module tb_mem_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int MAX_LOCK = 4;
  localparam int DEPTH    = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_write = '0;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [ADDR_W-1:0] req_addr1 = '0;
  logic [DATA_W-1:0] req_wdata0 = '0;
  logic [DATA_W-1:0] req_wdata1 = '0;
  logic              lock1 = 1'b0;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .lock1      (lock1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Data memory seen by the DUT: writes land on the edge, reads return one cycle later.
  logic [DATA_W-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        env_mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= env_mem[mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state: memory contents, last winner, consecutive port-1 wins
  // while port 0 waited, and the response owed in the next cycle.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                m_last;
  int                m_run;
  bit                m_pend;
  int                m_pend_port;
  logic [DATA_W-1:0] m_pend_data;

  logic [1:0] seen_ready;
  logic [1:0] seen_rsp;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_last = 1;
    m_run  = 0;
    m_pend = 1'b0;
  endtask

  // Winner from the arbitration rules: -1 none, else the port index.
  function automatic int modelWinner(input logic [1:0] v, input logic lk);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (m_run >= MAX_LOCK) return 0;
    if (lk && m_last == 1) return 1;
    return 1 - m_last;
  endfunction

  // Drive one cycle of requests (called just after a rising edge), check every
  // output mid-cycle against the model, then advance the model on the next edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                               input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic lk);
    int                win;
    logic [1:0]        eg;
    logic              ww;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [1:0]        er;
    logic [DATA_W-1:0] ed;
    req_valid  = v;
    req_write  = w;
    req_addr0  = a0;
    req_addr1  = a1;
    req_wdata0 = d0;
    req_wdata1 = d1;
    lock1      = lk;
    win = modelWinner(v, lk);
    eg  = (win < 0) ? 2'b00 : ((win == 0) ? 2'b01 : 2'b10);
    ww  = (win == 1) ? w[1] : w[0];
    wa  = (win == 1) ? a1 : a0;
    wd  = (win == 1) ? d1 : d0;
    if (win < 0) begin
      ww = 1'b0;
      wa = '0;
      wd = '0;
    end
    er = m_pend ? ((m_pend_port == 1) ? 2'b10 : 2'b01) : 2'b00;
    ed = m_pend ? m_pend_data : '0;
    @(negedge clk);
    seen_ready = req_ready;
    seen_rsp   = rsp_valid;
    checkOutput("req_ready", 64'(req_ready), 64'(eg));
    checkOutput("mem_en",    64'(mem_en),    64'(win >= 0));
    checkOutput("mem_we",    64'(mem_we),    64'(ww));
    checkOutput("mem_addr",  64'(mem_addr),  64'(wa));
    checkOutput("mem_wdata", 64'(mem_wdata), 64'(wd));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(er));
    checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(ed));
    @(posedge clk);
    if (win >= 0) begin
      m_pend      = 1'b1;
      m_pend_port = win;
      m_pend_data = ww ? '0 : ref_mem[wa];
      if (ww) ref_mem[wa] = wd;
      m_last = win;
      if (win == 0 || !v[0]) m_run = 0;
      else if (m_run < MAX_LOCK) m_run++;
    end else begin
      m_pend = 1'b0;
      if (!v[0]) m_run = 0;
    end
    #1;
  endtask

  // Assert reset with both ports requesting, check every output is zero, then
  // release mid-cycle with requests withdrawn.
  task automatic doReset();
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_write  = 2'b11;
    req_addr0  = ADDR_W'($urandom_range(1, 63));
    req_addr1  = ADDR_W'($urandom_range(1, 63));
    req_wdata0 = DATA_W'($urandom) | 32'h1;
    req_wdata1 = DATA_W'($urandom) | 32'h1;
    lock1      = 1'b1;
    modelReset();
    #2;
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    checkOutput("rst_mem_en",    64'(mem_en),    64'(0));
    checkOutput("rst_mem_we",    64'(mem_we),    64'(0));
    checkOutput("rst_mem_addr",  64'(mem_addr),  64'(0));
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_hold_rsp",   64'(rsp_valid), 64'(0));
    checkOutput("rst_hold_en",    64'(mem_en),    64'(0));
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] ALT_SEQ  [6]  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  localparam logic [1:0] LOCK_SEQ [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                           2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

  // Main sequence: reset, memory fill, directed scenarios, then randomized traffic.
  initial begin
    logic [1:0]        hv;
    logic [1:0]        hw;
    logic [ADDR_W-1:0] ha0;
    logic [ADDR_W-1:0] ha1;
    logic [DATA_W-1:0] hd0;
    logic [DATA_W-1:0] hd1;
    logic              lk;
    logic [DATA_W-1:0] exp_data [3];

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #1;
    doReset();

    // Fill every word through port 0 so both memories hold known values.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(2'b01, 2'b01, ADDR_W'(i), '0, DATA_W'($urandom), '0, 1'b0);

    // Store then load on port 0, address 12.
    applyStimulus(2'b01, 2'b01, 6'd12, '0, 32'd5, '0, 1'b0);
    checkOutput("st_ack_valid", 64'(rsp_valid), 64'(2'b01));
    checkOutput("st_ack_rdata", 64'(rsp_rdata), 64'(0));
    applyStimulus(2'b01, 2'b00, 6'd12, '0, '0, '0, 1'b0);
    checkOutput("ld_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    checkOutput("ld_rsp_rdata", 64'(rsp_rdata), 64'(5));
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);

    // Continuous contention without lock alternates, port 0 first after reset.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 2'b00, 6'd3, 6'd4, '0, '0, 1'b0);
      checkOutput("rr_alternate", 64'(seen_ready), 64'(ALT_SEQ[i]));
    end

    // Locked contention: MAX_LOCK port-1 grants, one port-0 grant, repeat.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b11, 2'b00, 6'd3, 6'd4, '0, '0, 1'b1);
      checkOutput("lock_seq", 64'(seen_ready), 64'(LOCK_SEQ[i]));
    end
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);

    // Back-to-back port-1 loads of 13, 14, 15.
    exp_data[0] = 32'd5;
    exp_data[1] = 32'd2;
    exp_data[2] = 32'd7;
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b10, 2'b10, '0, ADDR_W'(13 + i), '0, exp_data[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b10, 2'b00, '0, ADDR_W'(13 + i), '0, '0, 1'b0);
      checkOutput("b2b_ready", 64'(seen_ready), 64'(2'b10));
      checkOutput("b2b_rdata", 64'(rsp_rdata), 64'(exp_data[i]));
    end

    // Port-0 response overlapping a port-1 accept.
    applyStimulus(2'b01, 2'b00, 6'd20, '0, '0, '0, 1'b0);
    applyStimulus(2'b10, 2'b00, '0, 6'd21, '0, '0, 1'b0);
    checkOutput("overlap_rsp",   64'(seen_rsp),   64'(2'b01));
    checkOutput("overlap_ready", 64'(seen_ready), 64'(2'b10));
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);

    // Reset in the cycle after a load accept drops its response.
    applyStimulus(2'b01, 2'b00, 6'd12, '0, '0, '0, 1'b0);
    doReset();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    checkOutput("rst_drop_rsp", 64'(seen_rsp), 64'(0));

    // Randomized traffic; a request stays stable until it is accepted.
    hv = 2'b00;
    hw = 2'b00;
    ha0 = '0;
    ha1 = '0;
    hd0 = '0;
    hd1 = '0;
    lk = 1'b0;
    seen_ready = 2'b00;
    for (int c = 0; c < 600; c++) begin
      if (!hv[0] || seen_ready[0]) begin
        hv[0] = ($urandom_range(3) != 0);
        hw[0] = 1'($urandom_range(1));
        ha0   = ADDR_W'($urandom_range(15));
        hd0   = DATA_W'($urandom);
      end
      if (!hv[1] || seen_ready[1]) begin
        hv[1] = ($urandom_range(3) != 0);
        hw[1] = 1'($urandom_range(1));
        ha1   = ADDR_W'($urandom_range(15));
        hd1   = DATA_W'($urandom);
      end
      if ($urandom_range(15) == 0) lk = ~lk;
      applyStimulus(hv, hw, ha0, ha1, hd0, hd1, lk);
    end
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, LC2K word width.
REQ-002 Parameter ADDR_W, default 6, data-memory word address width (64 words).
REQ-003 Parameter MAX_LOCK, default 16, max consecutive port-1 grants under lock while port 0 waits.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  2  per-port request valid; bit 0 = CPU load/store, bit 1 = loader/debug.
REQ-007 req_write  in  2  per-port: 1 = store, 0 = load.
REQ-008 req_addr0, req_addr1  in  ADDR_W each  per-port word address.
REQ-009 req_wdata0, req_wdata1  in  DATA_W each  per-port store data.
REQ-010 lock1  in  1  port 1 requests back-to-back grants (burst program load).
REQ-011 req_ready  out  2  per-port accept; transfer occurs when req_valid[i] & req_ready[i].
REQ-012 rsp_valid  out  2  per-port one-cycle response strobe.
REQ-013 rsp_rdata  out  DATA_W  shared response data; meaningful only with rsp_valid.
REQ-014 mem_en, mem_we  out  1 each  memory access strobe and write enable.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory command.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-017 At most one bit of req_ready SHALL be high per cycle; req_ready is combinational from req_valid and registered state.
REQ-018 On accept, mem_en=1 and mem_we/mem_addr/mem_wdata SHALL equal the winner's request in that same cycle; otherwise mem_en=0, mem_we=0.
REQ-019 Response latency SHALL be exactly 1 cycle: rsp_valid[winner]=1 in the cycle after accept, for one cycle.
REQ-020 Load response: rsp_rdata=mem_rdata; store response (ack): rsp_rdata=0.
REQ-021 Accept SHALL be allowed in every cycle, including a response cycle; sustained throughput 1 access/cycle.
REQ-022 FSM states: IDLE (no response pending), PEND (response pending, tagged with port and write flag); IDLE->PEND on accept; PEND->PEND on new accept; PEND->IDLE otherwise.
REQ-023 Arbitration: single requester wins; both valid -> port not granted most recently wins (round-robin); last-grant pointer resets to port 1, so port 0 wins first contention.
REQ-024 Lock: lock1=1 with both valid and last grant=1 -> port 1 wins, overriding round-robin.
REQ-025 Lock counter counts consecutive port-1 grants made while req_valid[0]=1; at MAX_LOCK, next contention SHALL go to port 0 and counter clears.
REQ-026 Counter SHALL clear on any port-0 grant or when req_valid[0]=0; saturates, never wraps.
REQ-027 Requesters SHALL hold request fields stable while valid and not ready; arbiter need not check.
REQ-028 Accept and response in same cycle SHALL target independent ports without interference (rsp for old port, ready for new port).

Reset
REQ-029 On rst_n=0, immediately: state=IDLE, last grant=1, lock counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset while PEND SHALL drop the pending response; no rsp_valid after release.
REQ-031 First accept possible in the first rising edge after rst_n deasserts.

Structure
REQ-032 DATA_W, ADDR_W defaults, port index constants (PORT_CPU=0, PORT_DBG=1) and the FSM state type SHALL live in shared package lc2k_pkg.
REQ-033 Two-way round-robin/lock selection SHALL be sub-module rr_arbiter2; mem_arbiter holds FSM, response tag and mux.

Verification
REQ-034 Port 0 store addr 12 data 5, then load addr 12 -> ack rsp_valid=2'b01 rdata 0; next rsp rdata 5, each 1 cycle after accept.
REQ-035 Both valid continuously, lock1=0 -> grants alternate 0,1,0,1; first grant port 0.
REQ-036 Both valid, lock1=1, MAX_LOCK=4, last grant=1 -> four port-1 grants, then one port-0 grant, then port 1 resumes.
REQ-037 Back-to-back loads port 1 addrs 13,14,15 holding 5,2,7 -> req_ready[1] three consecutive cycles, rsp rdata 5,2,7 on following cycles.
REQ-038 rst_n low the cycle after load accept -> no rsp_valid ever for it; all outputs 0 during reset.
REQ-039 Port 0 response cycle coincides with port 1 accept -> rsp_valid=2'b01 and req_ready=2'b10 same cycle, mem command from port 1.
